// File: rtl/npu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : npu_loader
//  Description : Streams image, conv-weight, fc2-weight and fc1-weight words
//                into the NPU host write port. It interleaves the conv
//                trigger/next control writes with fixed idle windows and the
//                per-group fc1 strobes. The sequence ends with a one-cycle
//                done pulse.
//                Optional feature: define NPU_LOADER_CHKSUM_EN to enable the
//                running XOR checksum of accepted words. When it is not
//                defined, chksum is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module npu_loader #(
    parameter int IMG_WORDS  = 60,
    parameter int WC_WORDS   = 3,
    parameter int FC2_WORDS  = 3,
    parameter int FC1_GROUPS = 330,
    parameter int CONV_WAIT  = 256
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    output logic        busy,
    output logic        done,
    output logic [31:0] chksum
);

    // One counter serves the word phases and the idle window. It is at least
    // 12 bits wide so that it can drive idx directly.
    localparam int c_MAX_A  = (IMG_WORDS > CONV_WAIT) ? IMG_WORDS : CONV_WAIT;
    localparam int c_MAX_B  = (c_MAX_A > WC_WORDS) ? c_MAX_A : WC_WORDS;
    localparam int c_MAX    = (c_MAX_B > FC2_WORDS) ? c_MAX_B : FC2_WORDS;
    localparam int c_CW_RAW = $clog2(c_MAX + 1);
    localparam int c_CW     = (c_CW_RAW > 12) ? c_CW_RAW : 12;
    localparam int c_GW     = $clog2(FC1_GROUPS + 1);

    localparam logic [2:0] c_SEL_IMG = 3'b001;
    localparam logic [2:0] c_SEL_WC  = 3'b010;
    localparam logic [2:0] c_SEL_FC2 = 3'b100;
    localparam logic [2:0] c_SEL_FC1 = 3'b011;
    localparam logic [2:0] c_SEL_CTL = 3'b101;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_IMG   = 4'd1,
        ST_WC    = 4'd2,
        ST_FC2   = 4'd3,
        ST_TRIG  = 4'd4,
        ST_WAIT  = 4'd5,
        ST_NEXT  = 4'd6,
        ST_FC1_W = 4'd7,
        ST_FC1_S = 4'd8,
        ST_FC1_N = 4'd9,
        ST_DONE  = 4'd10
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_GW-1:0]   r_grp;
    logic              r_layer;   // 0: conv1 in progress, 1: conv2 in progress
    logic              r_ena;
    logic              r_wea;
    logic [15:0]       r_addra;
    logic [31:0]       r_dina;
    logic              r_busy;
    logic              r_done;

    logic              w_data_st;
    logic              w_accept;
    logic [2:0]        w_sel;
    logic [c_CW-1:0]   w_last;
    state_t            w_next;

    assign w_data_st = (r_state == ST_IMG) || (r_state == ST_WC) ||
                       (r_state == ST_FC2) || (r_state == ST_FC1_W);
    // abort masks ready so that a beat offered in the abort cycle is refused
    assign s_ready   = w_data_st && !abort;
    assign w_accept  = s_valid && s_ready;

    // Per-phase select, last word index and successor for the bulk word phases
    always_comb begin
        w_sel  = c_SEL_IMG;
        w_last = c_CW'(IMG_WORDS - 1);
        w_next = ST_WC;
        case (r_state)
            ST_WC: begin
                w_sel  = c_SEL_WC;
                w_last = c_CW'(WC_WORDS - 1);
                w_next = ST_FC2;
            end
            ST_FC2: begin
                w_sel  = c_SEL_FC2;
                w_last = c_CW'(FC2_WORDS - 1);
                w_next = ST_TRIG;
            end
            default: begin
                w_sel  = c_SEL_IMG;
                w_last = c_CW'(IMG_WORDS - 1);
                w_next = ST_WC;
            end
        endcase
    end

    // Sequencer: state, counters and registered write-port/status outputs
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_grp   <= '0;
            r_layer <= 1'b0;
            r_ena   <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= 16'd0;
            r_dina  <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ena  <= 1'b0;
            r_wea  <= 1'b0;
            r_done <= 1'b0;
            if (r_state != ST_IDLE && abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_grp   <= '0;
                r_layer <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_IMG;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_grp   <= '0;
                            r_layer <= 1'b0;
                        end
                    end
                    ST_IMG, ST_WC, ST_FC2: begin
                        if (w_accept) begin
                            r_ena   <= 1'b1;
                            r_wea   <= 1'b1;
                            r_addra <= {1'b0, w_sel, r_cnt[11:0]};
                            r_dina  <= s_data;
                            if (r_cnt == w_last) begin
                                r_cnt   <= '0;
                                r_state <= w_next;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_TRIG: begin
                        r_ena   <= 1'b1;
                        r_wea   <= 1'b1;
                        r_addra <= {1'b0, c_SEL_CTL, 12'd0};
                        r_dina  <= 32'h1;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (r_cnt == c_CW'(CONV_WAIT - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_NEXT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        r_ena   <= 1'b1;
                        r_wea   <= 1'b1;
                        r_addra <= {1'b0, c_SEL_CTL, 12'd0};
                        r_dina  <= 32'h8;
                        if (!r_layer) begin
                            r_layer <= 1'b1;
                            r_state <= ST_TRIG;
                        end else begin
                            r_state <= ST_FC1_W;
                        end
                    end
                    ST_FC1_W: begin
                        if (w_accept) begin
                            r_ena   <= 1'b1;
                            r_wea   <= 1'b1;
                            r_addra <= {1'b0, c_SEL_FC1, 12'd0};
                            r_dina  <= s_data;
                            r_state <= ST_FC1_S;
                        end
                    end
                    ST_FC1_S: begin
                        r_ena   <= 1'b1;
                        r_wea   <= 1'b1;
                        r_addra <= {1'b0, c_SEL_CTL, 12'd2};
                        r_dina  <= 32'd0;
                        r_state <= ST_FC1_N;
                    end
                    ST_FC1_N: begin
                        r_ena   <= 1'b1;
                        r_wea   <= 1'b1;
                        r_addra <= {1'b0, c_SEL_CTL, 12'd3};
                        r_dina  <= 32'd0;
                        if (r_grp == c_GW'(FC1_GROUPS - 1)) begin
                            r_grp   <= '0;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_grp   <= r_grp + 1'b1;
                            r_state <= ST_FC1_W;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ena   = r_ena;
    assign wea   = r_wea;
    assign addra = r_addra;
    assign dina  = r_dina;
    assign busy  = r_busy;
    assign done  = r_done;

`ifdef NPU_LOADER_CHKSUM_EN
    logic [31:0] r_chksum;

    // Running XOR of accepted words, restarted by each accepted start
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chksum <= 32'd0;
        end else if (r_state == ST_IDLE && start) begin
            r_chksum <= 32'd0;
        end else if (w_accept) begin
            r_chksum <= r_chksum ^ s_data;
        end
    end

    assign chksum = r_chksum;
`else
    assign chksum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_loader
//  Description : Self-checking bench for npu_loader (small CONV_WAIT and
//                FC1_GROUPS). Expected write streams are derived from the
//                load order of the sequence, not from the design's states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_loader;

    localparam int c_IMG   = 60;
    localparam int c_WC    = 3;
    localparam int c_FC2   = 3;
    localparam int c_GRP   = 2;
    localparam int c_WAIT  = 4;
    localparam int c_TOTAL = c_IMG + c_WC + c_FC2 + c_GRP;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_ready, ena, wea, busy, done;
    logic [15:0] addra;
    logic [31:0] dina, chksum;

    npu_loader #(
        .IMG_WORDS (c_IMG),
        .WC_WORDS  (c_WC),
        .FC2_WORDS (c_FC2),
        .FC1_GROUPS(c_GRP),
        .CONV_WAIT (c_WAIT)
    ) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .start  (start),
        .abort  (abort),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .ena    (ena),
        .wea    (wea),
        .addra  (addra),
        .dina   (dina),
        .busy   (busy),
        .done   (done),
        .chksum (chksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addra;
        logic [31:0] dina;
        logic [31:0] cyc;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } acc_t;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic        restart;
        logic [31:0] exp_xor;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tcyc = 0;
    int          done_cnt = 0;
    logic        trig_seen = 1'b0;
    wr_t         wlog[$];
    acc_t        alog[$];
    wr_t         exp_q[$];
    logic [31:0] bq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) tcyc <= tcyc + 1;

    // Observe the write port, accepted beats and the done pulse
    always @(negedge clk) begin
        if (ena || wea) begin
            chk("ena_eq_wea", {63'd0, ena}, {63'd0, wea});
            wlog.push_back('{addra: addra, dina: dina, cyc: tcyc});
            if (addra == 16'h5000 && dina == 32'h1) trig_seen = 1'b1;
        end
        if (s_valid && s_ready) alog.push_back('{data: s_data, cyc: tcyc});
        if (done) begin
            done_cnt++;
            chk("busy_at_done", {63'd0, busy}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        wlog.delete();
        alog.delete();
        done_cnt  = 0;
        trig_seen = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back('{addra: a, dina: d, cyc: 32'd0});
    endtask

    // Expected write order: image, weights, two conv layers, fc1 groups
    task automatic build_exp();
        int k;
        k = 0;
        exp_q.delete();
        for (int i = 0; i < c_IMG; i++) begin push_exp(16'h1000 + 16'(i), bq[k]); k++; end
        for (int i = 0; i < c_WC; i++)  begin push_exp(16'h2000 + 16'(i), bq[k]); k++; end
        for (int i = 0; i < c_FC2; i++) begin push_exp(16'h4000 + 16'(i), bq[k]); k++; end
        for (int l = 0; l < 2; l++) begin
            push_exp(16'h5000, 32'h1);
            push_exp(16'h5000, 32'h8);
        end
        for (int g = 0; g < c_GRP; g++) begin
            push_exp(16'h3000, bq[k]); k++;
            push_exp(16'h5002, 32'h0);
            push_exp(16'h5003, 32'h0);
        end
    endtask

    // mode 0: valid every cycle, 1: valid toggles, 2: random valid
    task automatic run_seq(input int mode, input bit pattern);
        int          idx;
        int          cyc;
        int          j;
        logic [31:0] x;
        logic [2:0]  sel;
        bq.delete();
        x = 32'd0;
        for (int k = 0; k < c_TOTAL; k++) begin
            bq.push_back((pattern && k < c_IMG) ? 32'h03020100 + 32'(k) : $urandom);
            x = x ^ bq[k];
        end
        clear_logs();
        pulse_start();
        idx = 0;
        cyc = 0;
        while (idx < c_TOTAL && cyc < 2000) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = bq[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        chk("beats_fed", idx, c_TOTAL);
        for (int w = 0; w < 20 && done_cnt == 0; w++) tick();
        repeat (3) tick();
        build_exp();
        chk("wr_count", wlog.size(), exp_q.size());
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++) begin
            chk("wr_addra", wlog[i].addra, exp_q[i].addra);
            chk("wr_dina", wlog[i].dina, exp_q[i].dina);
        end
        chk("accept_count", alog.size(), c_TOTAL);
        j = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            sel = wlog[i].addra[14:12];
            if (sel != 3'b101 && j < alog.size()) begin
                chk("accept_to_write", wlog[i].cyc - alog[j].cyc, 1);
                j++;
            end
            if (wlog[i].addra == 16'h5000 && wlog[i].dina == 32'h1 && i + 1 < wlog.size())
                chk("conv_gap", wlog[i+1].cyc - wlog[i].cyc, c_WAIT + 1);
        end
        chk("done_pulses", done_cnt, 1);
        @(negedge clk);
        chk("busy_after", {63'd0, busy}, 64'd0);
`ifdef NPU_LOADER_CHKSUM_EN
        chk("chksum_seq", chksum, x);
`else
        chk("chksum_seq", chksum, 32'd0);
`endif
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   b;
        int   guard;
        logic [31:0] w3[3];

        tbl[0] = '{32'hFFFF0000, 32'h0000FFFF, 32'h12345678, 1'b0, 32'hEDCBA987};
        tbl[1] = '{32'h00000001, 32'h00000002, 32'h00000004, 1'b1, 32'h00000007};
        tbl[2] = '{32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0, 32'hFFFFFFFF};
        tbl[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h0000000F, 1'b1, 32'h0000000F};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ena", {63'd0, ena}, 0);
        chk("rst_wea", {63'd0, wea}, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_s_ready", {63'd0, s_ready}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_chksum", chksum, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Three-beat vectors: checksum, write index, start-while-busy ignored
        for (int r = 0; r < 4; r++) begin
            w3[0] = tbl[r].w0;
            w3[1] = tbl[r].w1;
            w3[2] = tbl[r].w2;
            pulse_start();
            chk("tbl_busy", {63'd0, busy}, 1);
            b = 0;
            guard = 0;
            while (b < 3 && guard < 20) begin
                s_valid = 1'b1;
                s_data  = w3[b];
                start   = tbl[r].restart && (b == 1);
                @(negedge clk);
                if (s_valid && s_ready) b++;
                tick();
                guard++;
            end
            s_valid = 1'b0;
            start   = 1'b0;
            @(negedge clk);
`ifdef NPU_LOADER_CHKSUM_EN
            chk("tbl_chksum", chksum, tbl[r].exp_xor);
`else
            chk("tbl_chksum", chksum, 32'd0);
`endif
            chk("tbl_addra", addra, 16'h1002);
            chk("tbl_dina", dina, tbl[r].w2);
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            @(negedge clk);
            chk("tbl_abort_busy", {63'd0, busy}, 0);
            tick();
        end

        // Full sequences under several valid patterns
        run_seq(0, 1'b1);
        run_seq(1, 1'b0);
        run_seq(2, 1'b0);
        run_seq(2, 1'b0);

        // Abort on image beat 10 while a beat is offered
        clear_logs();
        pulse_start();
        b = 0;
        guard = 0;
        while (b < 10 && guard < 50) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(negedge clk);
            if (s_valid && s_ready) b++;
            tick();
            guard++;
        end
        s_valid = 1'b1;
        s_data  = 32'hBADBAD00;
        abort   = 1'b1;
        @(negedge clk);
        chk("abort_s_ready", {63'd0, s_ready}, 0);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 0);
        chk("abort_ena", {63'd0, ena}, 0);
        chk("abort_done", {63'd0, done}, 0);
        repeat (3) tick();
        chk("abort_writes", wlog.size(), 10);
        chk("abort_accepts", alog.size(), 10);
        chk("abort_done_cnt", done_cnt, 0);
        run_seq(0, 1'b0);

        // Asynchronous reset during the conv idle window
        clear_logs();
        pulse_start();
        guard = 0;
        while (!trig_seen && guard < 200) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        chk("reached_wait", {63'd0, trig_seen}, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_ena", {63'd0, ena}, 0);
        chk("arst_wea", {63'd0, wea}, 0);
        chk("arst_addra", addra, 0);
        chk("arst_dina", dina, 0);
        chk("arst_s_ready", {63'd0, s_ready}, 0);
        chk("arst_busy", {63'd0, busy}, 0);
        chk("arst_done", {63'd0, done}, 0);
        chk("arst_chksum", chksum, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        run_seq(2, 1'b0);
        if (wlog.size() > 0) chk("first_write_after_rst", wlog[0].addra, 16'h1000);
        else chk("first_write_after_rst", 64'd0, 16'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
